// File: rtl/draw_marks.sv
// rtl/draw_marks.sv - animated X/O mark renderer for a small grid board
module draw_marks #(
  parameter int GRID_N       = 3,
  parameter int ORIGIN_X     = 15,
  parameter int ORIGIN_Y     = 9,
  parameter int PITCH_X      = 33,
  parameter int PITCH_Y      = 22,
  parameter int MARK_HALF    = 6,
  parameter int THICK        = 2,
  parameter int BLINK_FRAMES = 15
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         frame_tick,
  input  logic [6:0]                   x,
  input  logic [5:0]                   y,
  input  logic [2*GRID_N*GRID_N-1:0]   grid_data,
  input  logic [GRID_N*GRID_N-1:0]     win_mask,
  input  logic [15:0]                  color_x,
  input  logic [15:0]                  color_o,
  input  logic [15:0]                  color_win,
  output logic [15:0]                  oled_data,
  output logic                         anim_busy
);

  localparam int NCELL = GRID_N * GRID_N;
  localparam int SZW   = (MARK_HALF < 1) ? 1 : $clog2(MARK_HALF + 1);
  localparam int BCW   = (BLINK_FRAMES < 2) ? 1 : $clog2(BLINK_FRAMES);

  localparam logic [SZW-1:0] SZ_MAX  = SZW'(MARK_HALF);
  localparam logic [SZW-1:0] SZ_ONE  = SZW'(1);
  localparam logic [BCW-1:0] BC_LAST = BCW'(BLINK_FRAMES - 1);
  localparam logic [BCW-1:0] BC_ONE  = BCW'(1);

  // Offsets are kept in 11-bit signed arithmetic so x - cx never wraps,
  // squared distances in 24-bit signed so the circle test never overflows.
  localparam logic signed [10:0] THICK_S = 11'(THICK);

  logic [BCW-1:0]          bc_q, bc_d;
  logic                    blink_q, blink_d;
  logic [15:0]             oled_q, oled_d;
  logic                    busy_q, busy_d;
  logic [NCELL-1:0]        busy_vec;
  logic [NCELL:0][15:0]    color_chain;

  // The end of the priority chain: no cell covers the pixel.
  assign color_chain[NCELL] = 16'h0000;

  for (genvar c = 0; c < NCELL; c++) begin : g_cell
    localparam logic signed [10:0] CX = 11'(ORIGIN_X + (c % GRID_N) * PITCH_X);
    localparam logic signed [10:0] CY = 11'(ORIGIN_Y + (c / GRID_N) * PITCH_Y);

    logic [1:0]              code_eff;
    logic [1:0]              prev_code_q;
    logic [SZW-1:0]          sz_q, sz_d;
    logic signed [10:0]      dx, dy, adx, ady, sdif, ssum, asdif, assum;
    logic signed [10:0]      szs, inner;
    logic signed [23:0]      dxw, dyw, szw, innw, d2, r2, ri2;
    logic                    x_hit, o_hit, hit;
    logic [15:0]             cell_color;

    // Code 11 is not a legal mark; treat it like an empty cell.
    assign code_eff = (grid_data[2*c +: 2] == 2'b11) ? 2'b00 : grid_data[2*c +: 2];

    // Size counter: restart on placement/swap or empty, else grow one step per frame.
    always_comb begin
      sz_d = sz_q;
      if ((code_eff == 2'b00) || (code_eff != prev_code_q)) begin
        sz_d = '0;
      end else if (frame_tick && (sz_q < SZ_MAX)) begin
        sz_d = sz_q + SZ_ONE;
      end
    end

    // Per-cell state registers.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        prev_code_q <= 2'b00;
        sz_q        <= '0;
      end else begin
        prev_code_q <= code_eff;
        sz_q        <= sz_d;
      end
    end

    // Hit tests for the current pixel against this cell's mark at its current size.
    always_comb begin
      dx    = $signed({4'b0000, x}) - CX;
      dy    = $signed({5'b00000, y}) - CY;
      adx   = dx[10] ? -dx : dx;
      ady   = dy[10] ? -dy : dy;
      sdif  = dx - dy;
      ssum  = dx + dy;
      asdif = sdif[10] ? -sdif : sdif;
      assum = ssum[10] ? -ssum : ssum;
      szs   = 11'(sz_q);
      inner = szs - THICK_S;
      dxw   = 24'(dx);
      dyw   = 24'(dy);
      szw   = 24'(szs);
      innw  = 24'(inner);
      d2    = dxw * dxw + dyw * dyw;
      r2    = szw * szw;
      ri2   = innw * innw;
      x_hit = (adx <= szs) && (ady <= szs) &&
              ((asdif <= THICK_S) || (assum <= THICK_S));
      // A ring thinner than the stroke collapses to a filled disc.
      o_hit = (d2 <= r2) && ((szs <= THICK_S) || (d2 > ri2));
      hit   = ((code_eff == 2'b01) && x_hit) || ((code_eff == 2'b10) && o_hit);
      if (win_mask[c] && blink_q) begin
        cell_color = color_win;
      end else if (code_eff == 2'b01) begin
        cell_color = color_x;
      end else begin
        cell_color = color_o;
      end
    end

    // Lower cell indices sit closer to the chain output, so they win overlaps.
    assign color_chain[c] = hit ? cell_color : color_chain[c+1];
    assign busy_vec[c]    = (code_eff != 2'b00) && (sz_q < SZ_MAX);
  end

  // Blink timer: free-runs on frame ticks only while some cell is marked as winning.
  always_comb begin
    bc_d    = bc_q;
    blink_d = blink_q;
    if (win_mask == '0) begin
      bc_d    = '0;
      blink_d = 1'b0;
    end else if (frame_tick) begin
      if (bc_q == BC_LAST) begin
        bc_d    = '0;
        blink_d = ~blink_q;
      end else begin
        bc_d = bc_q + BC_ONE;
      end
    end
  end

  // Output pixel and busy flag are computed from this cycle's inputs and state.
  always_comb begin
    oled_d = color_chain[0];
    busy_d = |busy_vec;
  end

  // Global registers: blink timer and the registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bc_q    <= '0;
      blink_q <= 1'b0;
      oled_q  <= 16'h0000;
      busy_q  <= 1'b0;
    end else begin
      bc_q    <= bc_d;
      blink_q <= blink_d;
      oled_q  <= oled_d;
      busy_q  <= busy_d;
    end
  end

  assign oled_data = oled_q;
  assign anim_busy = busy_q;

endmodule

// File: tb/tb_draw_marks.sv
// tb/tb_draw_marks.sv - self-checking bench for draw_marks
module tb_draw_marks;

  localparam logic [15:0] CX_C = 16'hF800;
  localparam logic [15:0] CO_C = 16'h07E0;
  localparam logic [15:0] CW_C = 16'h001F;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic [6:0]  x;
  logic [5:0]  y;
  logic [17:0] grid_m;
  logic [8:0]  win_m;
  logic [31:0] grid_4;
  logic [15:0] win_4;
  logic [7:0]  grid_ov;
  logic [3:0]  win_ov;
  logic [15:0] color_x, color_o, color_win;
  logic [15:0] oled_m, oled_4, oled_ov;
  logic        busy_m, busy_4, busy_ov;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    int          sel;
    logic [15:0] exp;
    string       name;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [17:0] grid;
    logic [6:0]  px;
    logic [5:0]  py;
    logic [15:0] exp;
  } vec_t;
  vec_t vt [17];

  always #5 clk = ~clk;

  draw_marks dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .x(x), .y(y),
    .grid_data(grid_m), .win_mask(win_m), .color_x(color_x), .color_o(color_o),
    .color_win(color_win), .oled_data(oled_m), .anim_busy(busy_m)
  );

  draw_marks #(.GRID_N(4), .PITCH_X(24), .PITCH_Y(16)) dut4 (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .x(x), .y(y),
    .grid_data(grid_4), .win_mask(win_4), .color_x(color_x), .color_o(color_o),
    .color_win(color_win), .oled_data(oled_4), .anim_busy(busy_4)
  );

  draw_marks #(.GRID_N(2), .PITCH_X(4), .PITCH_Y(4)) dut_ov (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .x(x), .y(y),
    .grid_data(grid_ov), .win_mask(win_ov), .color_x(color_x), .color_o(color_o),
    .color_win(color_win), .oled_data(oled_ov), .anim_busy(busy_ov)
  );

  task automatic check_bit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    logic [15:0] act;
    tests++;
    if (sb.size() == 0) begin
      failed++;
      $display("FAIL scoreboard: empty queue at output");
    end else begin
      e = sb.pop_front();
      act = (e.sel == 0) ? oled_m : (e.sel == 1) ? oled_4 : oled_ov;
      if (act !== e.exp) begin
        failed++;
        $display("FAIL %s: oled_data=%h expected %h", e.name, act, e.exp);
      end
    end
  endtask

  // Present a pixel, queue its expected colour, and compare one cycle later.
  task automatic probe(input int sel, input logic [6:0] px, input logic [5:0] py,
                       input logic [15:0] exp, input string name);
    exp_t e;
    x = px;
    y = py;
    e.sel  = sel;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
    @(posedge clk); #1;
    check_out();
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      @(posedge clk); #1;
      frame_tick = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{18'h00100, 7'd48, 6'd31, CX_C};
    vt[1]  = '{18'h00100, 7'd54, 6'd37, CX_C};
    vt[2]  = '{18'h00100, 7'd42, 6'd37, CX_C};
    vt[3]  = '{18'h00100, 7'd55, 6'd38, 16'h0000};
    vt[4]  = '{18'h00100, 7'd51, 6'd31, 16'h0000};
    vt[5]  = '{18'h00100, 7'd50, 6'd31, CX_C};
    vt[6]  = '{18'h00100, 7'd48, 6'd37, 16'h0000};
    vt[7]  = '{18'h00002, 7'd21, 6'd9,  CO_C};
    vt[8]  = '{18'h00002, 7'd15, 6'd9,  16'h0000};
    vt[9]  = '{18'h00002, 7'd22, 6'd9,  16'h0000};
    vt[10] = '{18'h00002, 7'd15, 6'd3,  CO_C};
    vt[11] = '{18'h00002, 7'd19, 6'd13, CO_C};
    vt[12] = '{18'h00002, 7'd17, 6'd10, 16'h0000};
    vt[13] = '{18'h20C01, 7'd15, 6'd9,  CX_C};
    vt[14] = '{18'h20C01, 7'd81, 6'd53, 16'h0000};
    vt[15] = '{18'h20C01, 7'd87, 6'd53, CO_C};
    vt[16] = '{18'h20C01, 7'd81, 6'd31, 16'h0000};

    reset = 1'b1; frame_tick = 1'b0; x = 7'd48; y = 6'd31;
    grid_m = 18'h00100; win_m = '0; grid_4 = '0; win_4 = '0; grid_ov = '0; win_ov = '0;
    color_x = CX_C; color_o = CO_C; color_win = CW_C;

    // Reset holds outputs at zero even with a mark under the pixel.
    @(posedge clk); @(posedge clk); #1;
    tests++;
    if (oled_m !== 16'h0000) begin
      failed++;
      $display("FAIL reset_oled: oled_data=%h expected 0000", oled_m);
    end
    check_bit("reset_busy", busy_m, 1'b0);
    grid_m = '0;
    reset = 1'b0;
    @(posedge clk); #1;

    // Placement, one-cycle latency, growth and busy flag.
    grid_m = 18'h00100;
    probe(0, 7'd54, 6'd37, 16'h0000, "place_corner_sz0");
    probe(0, 7'd48, 6'd31, CX_C, "place_centre_sz0");
    check_bit("place_busy", busy_m, 1'b1);
    tick(2);
    probe(0, 7'd51, 6'd34, 16'h0000, "grow_sz2");
    tick(1);
    probe(0, 7'd51, 6'd34, CX_C, "grow_sz3");
    check_bit("grow_busy", busy_m, 1'b1);
    tick(3);
    check_bit("busy_last_tick", busy_m, 1'b1);
    probe(0, 7'd54, 6'd37, CX_C, "full_corner");
    check_bit("busy_done", busy_m, 1'b0);
    tick(2);
    probe(0, 7'd55, 6'd38, 16'h0000, "saturated");

    // Full-size static rendering table.
    for (int i = 0; i < 17; i++) begin
      if (vt[i].grid !== grid_m) begin
        grid_m = vt[i].grid;
        tick(8);
      end
      probe(0, vt[i].px, vt[i].py, vt[i].exp, $sformatf("vec%0d", i));
    end

    // X->O swap coincident with a frame tick: load wins, then grow as O.
    grid_m = 18'h00010;
    tick(8);
    grid_m = 18'h00020;
    x = 7'd87; y = 6'd9;
    tick(1);
    probe(0, 7'd87, 6'd9, 16'h0000, "swap_sz0_outer");
    probe(0, 7'd82, 6'd9, 16'h0000, "swap_no_incr");
    check_bit("swap_busy", busy_m, 1'b1);
    tick(1);
    probe(0, 7'd82, 6'd9, CO_C, "swap_grow_o");

    // Winning line blink.
    grid_m = 18'h01111;
    tick(8);
    win_m = 9'b001_010_100;
    probe(0, 7'd48, 6'd31, CX_C, "win_phase0");
    tick(14);
    probe(0, 7'd48, 6'd31, CX_C, "win_bc14");
    tick(1);
    probe(0, 7'd48, 6'd31, CW_C, "win_c4");
    probe(0, 7'd81, 6'd9,  CW_C, "win_c2");
    probe(0, 7'd15, 6'd53, CW_C, "win_c6");
    probe(0, 7'd15, 6'd9,  CX_C, "nonwin_c0");
    tick(15);
    probe(0, 7'd48, 6'd31, CX_C, "win_phase_back");
    tick(15);
    tick(5);
    probe(0, 7'd48, 6'd31, CW_C, "win_phase1_again");
    win_m = '0;
    probe(0, 7'd48, 6'd31, CX_C, "win_cleared");
    win_m = 9'b001_010_100;
    probe(0, 7'd48, 6'd31, CX_C, "phase_reset");
    tick(14);
    probe(0, 7'd48, 6'd31, CX_C, "bc_reset");
    win_m = '0;

    // Asynchronous reset mid-animation, then regrowth from zero.
    grid_m = '0;
    tick(1);
    grid_m = 18'h00100;
    probe(0, 7'd51, 6'd34, 16'h0000, "pre_reset_sz0");
    tick(3);
    probe(0, 7'd51, 6'd34, CX_C, "pre_reset_sz3");
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if (oled_m !== 16'h0000) begin
      failed++;
      $display("FAIL async_reset_oled: oled_data=%h expected 0000", oled_m);
    end
    check_bit("async_reset_busy", busy_m, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    probe(0, 7'd51, 6'd34, 16'h0000, "regrow_sz0");
    check_bit("regrow_busy", busy_m, 1'b1);
    tick(2);
    probe(0, 7'd51, 6'd34, 16'h0000, "regrow_sz2");
    tick(1);
    probe(0, 7'd51, 6'd34, CX_C, "regrow_sz3");

    // 4x4 board: code 11 renders empty; X in cell 15 centred at (87,57).
    grid_4 = 32'hC000_0000;
    probe(1, 7'd87, 6'd57, 16'h0000, "g4_code11");
    check_bit("g4_code11_busy", busy_4, 1'b0);
    grid_4 = 32'h4000_0000;
    tick(8);
    probe(1, 7'd87, 6'd57, CX_C, "g4_centre");
    probe(1, 7'd93, 6'd63, CX_C, "g4_corner_br");
    probe(1, 7'd93, 6'd51, CX_C, "g4_corner_tr");
    probe(1, 7'd81, 6'd57, 16'h0000, "g4_side");

    // Overlapping cells: lowest index wins.
    grid_ov = 8'h06;
    tick(8);
    probe(2, 7'd21, 6'd9, CO_C, "ovl_low_wins");
    probe(2, 7'd19, 6'd9, CX_C, "ovl_cell1");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/draw_marks.md
DRAW_MARKS -- requirements
Module: draw_marks

Interface
REQ-001 Parameter GRID_N, default 3: board is GRID_N x GRID_N cells; cell c = row*GRID_N + col.
REQ-002 Parameter ORIGIN_X, default 15: x centre of column 0.
REQ-003 Parameter ORIGIN_Y, default 9: y centre of row 0.
REQ-004 Parameter PITCH_X, default 33: x distance between adjacent column centres.
REQ-005 Parameter PITCH_Y, default 22: y distance between adjacent row centres.
REQ-006 Parameter MARK_HALF, default 6: final mark half-size in pixels.
REQ-007 Parameter THICK, default 2: stroke half-thickness.
REQ-008 Parameter BLINK_FRAMES, default 15: frame ticks per blink phase.
REQ-009 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-010 clk  in  1  system clock.
REQ-011 reset  in  1  asynchronous active-high reset.
REQ-012 frame_tick  in  1  single-cycle pulse, once per OLED frame.
REQ-013 x  in  7  pixel column, 0..95.
REQ-014 y  in  6  pixel row, 0..63.
REQ-015 grid_data  in  2*GRID_N*GRID_N  cell codes; cell c uses bits [2c+1:2c]; 00 empty, 01 X, 10 O, 11 treated as empty.
REQ-016 win_mask  in  GRID_N*GRID_N  bit c set = cell c lies on the winning line.
REQ-017 color_x / color_o / color_win  in  16 each  RGB565 colours.
REQ-018 oled_data  out  16  registered pixel colour; 16'h0000 when no mark covers the pixel.
REQ-019 anim_busy  out  1  high while any non-empty cell is still growing.

Function
REQ-020 Per cell: 2-bit prev_code register and size counter sz, width ceil(log2(MARK_HALF+1)).
REQ-021 Every cycle, prev_code <= effective code (11 mapped to 00).
REQ-022 Effective code differs from prev_code and is non-empty (placement or X<->O swap): sz <= 0 that cycle.
REQ-023 Effective code is empty: sz <= 0.
REQ-024 Otherwise, on frame_tick with sz < MARK_HALF: sz <= sz+1; saturates at MARK_HALF.
REQ-025 Code change and frame_tick in the same cycle: the REQ-022/023 load wins; no increment.
REQ-026 Geometry: cell centre cx = ORIGIN_X + col*PITCH_X, cy = ORIGIN_Y + row*PITCH_Y.
REQ-027 Offsets dx = x-cx and dy = y-cy are computed signed, at least 9 bits wide; no wrap.
REQ-028 X hit: |dx|<=sz, |dy|<=sz, and (|dx-dy|<=THICK or |dx+dy|<=THICK).
REQ-029 O hit: dx*dx+dy*dy <= sz*sz, and either sz<=THICK or dx*dx+dy*dy > (sz-THICK)^2.
REQ-030 sz=0 on a non-empty cell covers only the centre pixel (dx=dy=0).
REQ-031 Colour: color_x for X, color_o for O; win_mask bit set and blink_phase=1 gives color_win.
REQ-032 Overlapping cells: the lowest cell index wins.
REQ-033 Blink: counter bc counts frame_ticks; at bc=BLINK_FRAMES-1 on a tick, bc<=0 and blink_phase toggles.
REQ-034 win_mask all zero: bc<=0 and blink_phase<=0 every cycle.
REQ-035 Latency: oled_data reflects x, y, grid_data and the state in cycle n at cycle n+1; exactly 1 cycle.
REQ-036 anim_busy is registered: it is 1 iff some cell has a non-empty code and sz<MARK_HALF, evaluated on the previous cycle's state.

Reset
REQ-037 While reset is high: oled_data=0, anim_busy=0, all sz=0, all prev_code=00, bc=0, blink_phase=0.
REQ-038 Reset asserted mid-animation aborts the animation immediately.
REQ-039 After reset release, cells that are already non-empty count as new placements and grow from sz=0.

Verification
REQ-040 Place X in cell 4, defaults, pulse 6 frame_ticks; pixel (48,31) during growth -> color_x one cycle after presentation; after 6 ticks (54,37) -> color_x, anim_busy 1->0.
REQ-041 O in cell 0, sz=6; (21,9) -> color_o; (15,9) -> 0 (ring hollow); (22,9) -> 0.
REQ-042 Cell 2 changes 01->10 in the same cycle as a frame_tick -> sz=0 next cycle, then grows as O.
REQ-043 win_mask=9'b001_010_100 with X in cells 2,4,6, all full size, 15 ticks -> those marks show color_win; 15 more ticks -> back to color_x; clear win_mask -> phase 0.
REQ-044 Assert reset at sz=3 -> oled_data=0 asynchronously; release with grid unchanged -> regrowth from sz=0.
REQ-045 GRID_N=4, PITCH_X=24, PITCH_Y=16, code 11 in cell 15 -> cell 15 renders as empty; X in cell 15 centred at (87,57).
